// File: rtl/core_seq_pkg.sv
// Shared types and constants for the byte-serial core sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a. Build option: CORE_SEQ_PC_READBACK_EN widens the readback to result + PC.
package core_seq_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      EXEC  = 2'd1,
      DRAIN = 2'd2
   } core_seq_state_e;

   localparam int InstrBytes = 4;

`ifdef CORE_SEQ_PC_READBACK_EN
   localparam int ReadbackBytes = 8;
`else
   localparam int ReadbackBytes = 4;
`endif

   localparam logic [31:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/core_sequencer_if.sv
// Bundle of the sequencer's byte streams and datapath-facing signals.
// Latency: n/a (wires only). Backpressure: byte_valid/byte_ready in, out_valid/out_ready out.
// Ports: slave = sequencer side, master = byte source / sink / datapath side.
interface core_sequencer_if;
   logic        flush;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [7:0]  byte_out;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] core_instr;
   logic        core_step;
   logic [31:0] core_alu_result;
   logic [31:0] core_pc;
   logic [15:0] retired_count;

   modport slave (
      input  flush, byte_in, byte_valid, out_ready, core_alu_result, core_pc,
      output byte_ready, byte_out, out_valid, core_instr, core_step, retired_count
   );

   modport master (
      output flush, byte_in, byte_valid, out_ready, core_alu_result, core_pc,
      input  byte_ready, byte_out, out_valid, core_instr, core_step, retired_count
   );
endinterface

// File: rtl/word_serializer.sv
// Parallel-load word buffer shifted out one byte at a time, LSB first.
// Latency: first byte valid the cycle after load_i; one byte per accepted handshake.
// Backpressure: out_vld_o/out_dat_o are registered and hold while out_rdy_i is low.
// Ports: clr_i drops the buffer, load_i captures load_dat_i, last_o marks the final byte.
module word_serializer #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr_i,
   input  logic                load_i,
   input  logic [8*NBYTES-1:0] load_dat_i,
   output logic                out_vld_o,
   output logic [7:0]          out_dat_o,
   input  logic                out_rdy_i,
   output logic                last_o
);
   localparam int CntW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [8*NBYTES-1:0] buf_q, buf_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                vld_q, vld_d;
   logic                last_w, take_w;

   assign last_w = (cnt_q == CntW'(NBYTES - 1));
   assign take_w = vld_q && out_rdy_i;

   always_comb begin
      buf_d = buf_q;
      cnt_d = cnt_q;
      vld_d = vld_q;
      if (clr_i) begin
         buf_d = '0;
         cnt_d = '0;
         vld_d = 1'b0;
      end else if (load_i) begin
         buf_d = load_dat_i;
         cnt_d = '0;
         vld_d = 1'b1;
      end else if (take_w) begin
         // Shifting keeps the current byte always in the low lane.
         buf_d = buf_q >> 8;
         cnt_d = cnt_q + CntW'(1);
         if (last_w) begin
            vld_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q <= '0;
         cnt_q <= '0;
         vld_q <= 1'b0;
      end else begin
         buf_q <= buf_d;
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   assign out_vld_o = vld_q;
   assign out_dat_o = buf_q[7:0];
   assign last_o    = last_w;
endmodule

// File: rtl/core_sequencer.sv
// Assembles 32-bit instructions from a byte stream, steps the datapath once, streams the result back.
// Latency: step the cycle after the 4th byte is taken; readback valid one cycle later.
// Backpressure: byte_ready low outside LOAD; readback holds while out_ready is low.
// Ports: clk/rst (sync, active-high), seq_if (slave modport of core_sequencer_if).
// Build option: CORE_SEQ_PC_READBACK_EN appends the executed instruction's PC to the readback.
module core_sequencer
   import core_seq_pkg::*;
#(
   parameter logic [31:0] RESET_INSTR = NopInstr
) (
   input  logic                  clk,
   input  logic                  rst,
   core_sequencer_if.slave       seq_if
);
   localparam logic [1:0] ST_LOAD  = LOAD;
   localparam logic [1:0] ST_EXEC  = EXEC;
   localparam logic [1:0] ST_DRAIN = DRAIN;

   logic [1:0]  state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   // Only lanes 0..2 need storage; the 4th byte goes straight into the instruction.
   logic [23:0] shadow_q, shadow_d;
   logic [31:0] instr_q, instr_d;
   logic        step_q, step_d;
   logic [15:0] retired_q, retired_d;
   logic        flush_pend_q, flush_pend_d;

   logic        flush_eff;
   logic        ser_load;
   logic        ser_vld, ser_last;
   logic [7:0]  ser_dat;
   logic        drain_done;
   logic [8*ReadbackBytes-1:0] rb_dat;

`ifdef CORE_SEQ_PC_READBACK_EN
   assign rb_dat = {seq_if.core_pc, seq_if.core_alu_result};
`else
   logic unused_pc;
   assign rb_dat    = seq_if.core_alu_result;
   assign unused_pc = ^seq_if.core_pc;
`endif

   // A flush raised during EXEC is held one cycle so the step always completes.
   assign flush_eff  = (seq_if.flush || flush_pend_q) && (state_q != ST_EXEC);
   assign drain_done = ser_vld && seq_if.out_ready && ser_last;

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      shadow_d     = shadow_q;
      instr_d      = instr_q;
      step_d       = 1'b0;
      retired_d    = retired_q;
      flush_pend_d = 1'b0;
      ser_load     = 1'b0;
      if (flush_eff) begin
         state_d    = ST_LOAD;
         byte_cnt_d = 2'd0;
         instr_d    = RESET_INSTR;
      end else begin
         case (state_q)
            ST_LOAD: begin
               if (seq_if.byte_valid) begin
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  case (byte_cnt_q)
                     2'd0:    shadow_d[7:0]   = seq_if.byte_in;
                     2'd1:    shadow_d[15:8]  = seq_if.byte_in;
                     2'd2:    shadow_d[23:16] = seq_if.byte_in;
                     default: instr_d         = {seq_if.byte_in, shadow_q};
                  endcase
                  if (byte_cnt_q == 2'(InstrBytes - 1)) begin
                     state_d = ST_EXEC;
                     step_d  = 1'b1;
                  end
               end
            end
            ST_EXEC: begin
               state_d      = ST_DRAIN;
               retired_d    = retired_q + 16'd1;
               ser_load     = 1'b1;
               flush_pend_d = seq_if.flush;
            end
            ST_DRAIN: begin
               if (drain_done) begin
                  state_d    = ST_LOAD;
                  byte_cnt_d = 2'd0;
               end
            end
            default: state_d = ST_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_LOAD;
         byte_cnt_q   <= 2'd0;
         shadow_q     <= '0;
         instr_q      <= RESET_INSTR;
         step_q       <= 1'b0;
         retired_q    <= 16'd0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         shadow_q     <= shadow_d;
         instr_q      <= instr_d;
         step_q       <= step_d;
         retired_q    <= retired_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   word_serializer #(
      .NBYTES (ReadbackBytes)
   ) u_ser (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (flush_eff),
      .load_i     (ser_load),
      .load_dat_i (rb_dat),
      .out_vld_o  (ser_vld),
      .out_dat_o  (ser_dat),
      .out_rdy_i  (seq_if.out_ready),
      .last_o     (ser_last)
   );

   assign seq_if.byte_ready    = (state_q == ST_LOAD);
   assign seq_if.byte_out      = ser_dat;
   assign seq_if.out_valid     = ser_vld;
   assign seq_if.core_instr    = instr_q;
   assign seq_if.core_step     = step_q;
   assign seq_if.retired_count = retired_q;
endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed byte streams, expected readback queued per instruction.
// Latency/backpressure exercised: step timing, stalled readback, flush (incl. during EXEC), reset in DRAIN.
// Build with CORE_SEQ_PC_READBACK_EN to also cover the PC readback.
module tb_core_sequencer;
   logic clk = 1'b0;
   logic rst;

   core_sequencer_if bus ();

   core_sequencer dut (
      .clk    (clk),
      .rst    (rst),
      .seq_if (bus)
   );

   always #5 clk = ~clk;

   int   checks      = 0;
   int   errors      = 0;
   int   step_cnt    = 0;
   int   exp_retired = 0;
   int   s0;
   bit   mon_en      = 1'b1;
   logic [7:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected readback for one executed instruction.
   task automatic push_rb(input logic [31:0] alu, input logic [31:0] pc);
      for (int i = 0; i < 4; i++) exp_q.push_back(alu[8*i +: 8]);
`ifdef CORE_SEQ_PC_READBACK_EN
      for (int i = 0; i < 4; i++) exp_q.push_back(pc[8*i +: 8]);
`else
      if (pc !== pc) exp_q.push_back(8'h00);
`endif
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      @(negedge clk);
      while (!bus.byte_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("send_byte_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_remaining", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("drain_byte_ready", 32'(bus.byte_ready), 32'd1);
      chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented readback byte must match the queue head; pop on handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && bus.core_step) step_cnt++;
         if (!rst && mon_en && bus.out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got byte %h with nothing expected", bus.byte_out);
            end else begin
               chk("byte_out", 32'(bus.byte_out), 32'(exp_q[0]));
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                 = 1'b1;
      bus.flush           = 1'b0;
      bus.byte_in         = 8'h00;
      bus.byte_valid      = 1'b0;
      bus.out_ready       = 1'b1;
      bus.core_alu_result = 32'h0;
      bus.core_pc         = 32'h0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_byte_ready", 32'(bus.byte_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_byte_out", 32'(bus.byte_out), 32'h00);
      chk("rst_core_step", 32'(bus.core_step), 32'd0);
      chk("rst_core_instr", bus.core_instr, 32'h0000_0013);
      chk("rst_retired", 32'(bus.retired_count), 32'd0);
      @(posedge clk);
      #1;

      // addi x1,x0,5 with no backpressure, including step/readback timing
      bus.core_alu_result = 32'd5;
      push_rb(32'd5, 32'd0);
      s0 = step_cnt;
      send_byte(8'h93); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
      @(negedge clk);
      chk("t2_instr", bus.core_instr, 32'h0050_0093);
      chk("t2_step_hi", 32'(bus.core_step), 32'd1);
      chk("t2_ready_exec", 32'(bus.byte_ready), 32'd0);
      chk("t2_valid_exec", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t2_step_lo", 32'(bus.core_step), 32'd0);
      chk("t2_valid_drain", 32'(bus.out_valid), 32'd1);
      wait_drain();
      exp_retired++;
      chk("t2_steps", 32'(step_cnt - s0), 32'd1);
      chk("t2_retired", 32'(bus.retired_count), 32'(exp_retired));

      // Same stream, readback stalled 3 cycles on the second byte, input offered meanwhile
      push_rb(32'd5, 32'd0);
      s0 = step_cnt;
      send_word(32'h0050_0093);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.out_ready  = 1'b0;
      bus.byte_in    = 8'hAA;
      bus.byte_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t3_ready_stall", 32'(bus.byte_ready), 32'd0);
         chk("t3_valid_stall", 32'(bus.out_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      bus.byte_valid = 1'b0;
      bus.out_ready  = 1'b1;
      wait_drain();
      exp_retired++;
      chk("t3_steps", 32'(step_cnt - s0), 32'd1);
      chk("t3_retired", 32'(bus.retired_count), 32'(exp_retired));

      // Partial word, flush colliding with a byte offer, then addi x2,x0,10
      s0 = step_cnt;
      send_byte(8'h93); send_byte(8'h00);
      bus.flush      = 1'b1;
      bus.byte_in    = 8'h55;
      bus.byte_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.flush      = 1'b0;
      bus.byte_valid = 1'b0;
      @(negedge clk);
      chk("t4_instr_flushed", bus.core_instr, 32'h0000_0013);
      chk("t4_ready_flushed", 32'(bus.byte_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.core_alu_result = 32'd10;
      push_rb(32'd10, 32'd0);
      send_word(32'h00A0_0113);
      @(negedge clk);
      chk("t4_instr", bus.core_instr, 32'h00A0_0113);
      wait_drain();
      exp_retired++;
      chk("t4_steps", 32'(step_cnt - s0), 32'd1);
      chk("t4_retired", 32'(bus.retired_count), 32'(exp_retired));

      // Flush during EXEC: step completes, readback dropped one cycle later
      mon_en              = 1'b0;
      bus.out_ready       = 1'b0;
      bus.core_alu_result = 32'h33;
      s0 = step_cnt;
      send_word(32'h0330_0093);
      bus.flush = 1'b1;
      @(negedge clk);
      chk("t4b_step", 32'(bus.core_step), 32'd1);
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      exp_retired++;
      chk("t4b_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t4b_instr", bus.core_instr, 32'h0000_0013);
      chk("t4b_byte_ready", 32'(bus.byte_ready), 32'd1);
      chk("t4b_retired", 32'(bus.retired_count), 32'(exp_retired));
      chk("t4b_steps", 32'(step_cnt - s0), 32'd1);
      @(posedge clk);
      #1;
      mon_en        = 1'b1;
      bus.out_ready = 1'b1;

      // Reset in DRAIN after the first readback byte
      bus.core_alu_result = 32'd7;
      exp_q.push_back(8'h07);
      s0 = step_cnt;
      send_word(32'h0070_0093);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_retired = 0;
      @(negedge clk);
      chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
      chk("t5_step", 32'(bus.core_step), 32'd0);
      chk("t5_instr", bus.core_instr, 32'h0000_0013);
      chk("t5_retired", 32'(bus.retired_count), 32'd0);
      chk("t5_first_byte_seen", 32'(exp_q.size()), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("t5_no_extra_step", 32'(step_cnt - s0), 32'd1);
      bus.core_alu_result = 32'd5;
      push_rb(32'd5, 32'd0);
      send_word(32'h0050_0093);
      @(negedge clk);
      chk("t5_reload_instr", bus.core_instr, 32'h0050_0093);
      wait_drain();
      exp_retired++;
      chk("t5_reload_retired", 32'(bus.retired_count), 32'(exp_retired));

`ifdef CORE_SEQ_PC_READBACK_EN
      // Two consecutive addi: PC 0 then PC 4 appended to the readback
      bus.core_pc         = 32'h0;
      bus.core_alu_result = 32'd5;
      push_rb(32'd5, 32'h0);
      send_word(32'h0050_0093);
      wait_drain();
      bus.core_pc         = 32'h4;
      bus.core_alu_result = 32'd10;
      push_rb(32'd10, 32'h4);
      send_word(32'h00A0_0113);
      wait_drain();
      exp_retired += 2;
      chk("t6_retired", 32'(bus.retired_count), 32'(exp_retired));
`endif

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
